// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit: queue entry layout,
// default queue depth and ROM word-address width.
package inst_fetch_unit_pkg;

  localparam int FETCH_DEPTH  = 4;
  localparam int FETCH_ADDR_W = 14;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // One buffered fetch: the PC it was fetched from plus the ROM word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bundle of PC-register, instruction-ROM and decode-side signals around the fetch unit.
// master = fetch unit, slave = surrounding pipeline (PC register, ROM, IF/ID stage).
interface inst_fetch_unit_if
  import inst_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DEPTH  = FETCH_DEPTH
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              inited;
  logic [31:0]       pc;
  logic              branch_flag;
  logic              stall;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  // Decode handshake: id_inst/id_pc are meaningful while id_valid=1; an entry is
  // consumed on every rising edge where id_valid & id_ready are both 1. id_valid
  // never depends combinationally on id_ready.
  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_inst;
  logic [31:0]       id_pc;
  logic [CNT_W-1:0]  fill_count;

  modport master (
    input  inited, pc, branch_flag, imem_rdata, id_ready,
    output stall, imem_en, imem_addr, id_valid, id_inst, id_pc, fill_count
  );

  modport slave (
    output inited, pc, branch_flag, imem_rdata, id_ready,
    input  stall, imem_en, imem_addr, id_valid, id_inst, id_pc, fill_count
  );

endinterface

// File: rtl/inst_fetch_unit_fifo.sv
// In-order fetch queue of {pc, inst} entries with push/pop/flush; flush clears
// occupancy and pointers and takes priority over a simultaneous push or pop.
module inst_fetch_unit_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     head,
  output logic             valid,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic             pop_ok;

  assign valid  = (count != '0);
  assign pop_ok = pop & valid;
  assign head   = mem[head_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      count    <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count    <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      if (push) begin
        mem[tail_ptr] <= wdata;
        tail_ptr      <= tail_ptr + PTR_W'(1);
      end
      if (pop_ok) head_ptr <= head_ptr + PTR_W'(1);
      // Simultaneous push and pop leaves the occupancy unchanged, even when full.
      case ({push, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop_ok && !flush && count == FULL));

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch unit: issues ROM reads for the current PC while queue credit remains,
// tags each read with its PC and buffers returned words for decode.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH  = FETCH_DEPTH,
  parameter int ADDR_W = FETCH_ADDR_W
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_unit_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(DEPTH);

  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  logic             inflight_v;
  logic [31:0]      inflight_pc;
  logic             credit_ok;
  logic             flush;
  logic             issue;
  logic             push;
  logic             pop;
  fetch_entry_t     wdata;
  fetch_entry_t     head;
  logic             head_valid;
  logic             unused_pc_bits;

  // Credit counts words already queued plus the one still in the ROM pipeline,
  // so a full queue is never overrun; it deliberately ignores id_ready.
  always_comb begin
    occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, inflight_v};
    credit_ok  = (occupancy < DEPTH_LIM);
    flush      = !bus.inited | bus.branch_flag;
    issue      = rst & bus.inited & credit_ok & !bus.branch_flag;
    push       = inflight_v;
    pop        = head_valid & bus.id_ready;
    wdata.pc   = inflight_pc;
    wdata.inst = bus.imem_rdata;
  end

  // A redirect must never be held off, otherwise the PC register drops the target.
  assign bus.stall      = !rst | !bus.inited | (!credit_ok & !bus.branch_flag);
  assign bus.imem_en    = issue;
  assign bus.imem_addr  = bus.pc[ADDR_W+1:2];
  assign unused_pc_bits = ^{bus.pc[31:ADDR_W+2], bus.pc[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight_v  <= 1'b0;
      inflight_pc <= ZERO_WORD;
    end else begin
      inflight_v <= issue;
      if (issue) inflight_pc <= bus.pc;
    end
  end

  inst_fetch_unit_fifo #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .wdata(wdata),
    .head (head),
    .valid(head_valid),
    .count(count)
  );

  assign bus.id_valid   = head_valid;
  assign bus.id_inst    = head.inst;
  assign bus.id_pc      = head.pc;
  assign bus.fill_count = count;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a PC-register model and a synchronous
// ROM whose word k holds 32'h1000_0000 + k.
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  localparam int ADDR_W = 14;
  localparam int DEPTH  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_unit_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  inst_fetch_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- environment models ----------------
  logic [31:0] pc_reg;
  logic [31:0] br_target;

  always @(posedge clk) begin
    if (!rst)                 pc_reg <= 32'h0;
    else if (bus.branch_flag) pc_reg <= br_target;
    else if (!bus.stall)      pc_reg <= pc_reg + 32'd4;
  end
  assign bus.pc = pc_reg;

  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= 32'h1000_0000 + 32'(bus.imem_addr);
  end

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'h1000_0000 + ((pc >> 2) & 32'h0000_3FFF);
  endfunction

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          seg;
    bit          rst;
    bit          inited;
    bit          ready;
    bit          br;
    logic [31:0] tgt;
    bit          stall;
    bit          en;
    int          addr;
    bit          cq;
    bit          valid;
    bit          zero;
    logic [31:0] pc;
    int          cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int seg, input bit r, input bit i, input bit rd, input bit br,
                     input logic [31:0] tgt, input bit st, input bit en, input int addr,
                     input bit cq, input bit vl, input bit z, input logic [31:0] pc,
                     input int cnt = -1);
    vec_t v;
    v.seg = seg; v.rst = r; v.inited = i; v.ready = rd; v.br = br; v.tgt = tgt;
    v.stall = st; v.en = en; v.addr = addr; v.cq = cq; v.valid = vl; v.zero = z;
    v.pc = pc; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // Two reset cycles; the second sees the post-reset register state.
  task automatic reset_rows(input int seg, input bit rd);
    add(seg, 0, 1, rd, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(seg, 0, 1, rd, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0);
  endtask

  // Issue from pc 0 with decode stalled: n cycles of the fill sequence.
  task automatic fill_rows(input int seg, input int n);
    if (n > 0) add(seg, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    if (n > 1) add(seg, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    if (n > 2) add(seg, 1, 1, 0, 0, 0, 0, 1, 2, 1, 1, 0, 0);
    if (n > 3) add(seg, 1, 1, 0, 0, 0, 0, 1, 3, 1, 1, 0, 0);
  endtask

  task automatic build_table();
    // seg 1: streaming from reset with decode always ready
    reset_rows(1, 1);
    add(1, 1, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0, 1, 2, 1, 1, 0, 32'h0);
    add(1, 1, 1, 1, 0, 0, 0, 1, 3, 1, 1, 0, 32'h4);
    add(1, 1, 1, 1, 0, 0, 0, 1, 4, 1, 1, 0, 32'h8);
    // seg 2: fill to DEPTH, stall, then drain in order and resume at 0x10
    reset_rows(2, 0);
    fill_rows(2, 4);
    add(2, 1, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 32'h0, 3);
    add(2, 1, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 32'h0, 4);
    add(2, 1, 1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 32'h0, 4);
    add(2, 1, 1, 1, 0, 0, 0, 1, 4, 1, 1, 0, 32'h4, 3);
    add(2, 1, 1, 1, 0, 0, 0, 1, 5, 1, 1, 0, 32'h8);
    add(2, 1, 1, 1, 0, 0, 0, 1, 6, 1, 1, 0, 32'hC);
    add(2, 1, 1, 1, 0, 0, 0, 1, 7, 1, 1, 0, 32'h10);
    add(2, 1, 1, 1, 0, 0, 0, 1, 8, 1, 1, 0, 32'h14);
    // seg 3: count=DEPTH-1 with push and pop on the same edge
    reset_rows(3, 0);
    fill_rows(3, 4);
    add(3, 1, 1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 32'h0, 3);
    add(3, 1, 1, 1, 0, 0, 0, 1, 4, 1, 1, 0, 32'h4, 3);
    add(3, 1, 1, 1, 0, 0, 0, 1, 5, 1, 1, 0, 32'h8);
    add(3, 1, 1, 1, 0, 0, 0, 1, 6, 1, 1, 0, 32'hC);
    add(3, 1, 1, 1, 0, 0, 0, 1, 7, 1, 1, 0, 32'h10);
    // seg 4: redirect to 0x40 with two queued and one in flight
    reset_rows(4, 0);
    fill_rows(4, 3);
    add(4, 1, 1, 0, 1, 32'h40, 0, 0, 0, 1, 1, 0, 32'h0, 2);
    add(4, 1, 1, 0, 0, 0, 0, 1, 16, 1, 0, 0, 32'h0, 0);
    add(4, 1, 1, 0, 0, 0, 0, 1, 17, 1, 0, 0, 32'h0);
    add(4, 1, 1, 1, 0, 0, 0, 1, 18, 1, 1, 0, 32'h40);
    add(4, 1, 1, 1, 0, 0, 0, 1, 19, 1, 1, 0, 32'h44);
    add(4, 1, 1, 1, 0, 0, 0, 1, 20, 1, 1, 0, 32'h48);
    // seg 5: redirect while full releases stall in the same cycle
    reset_rows(5, 0);
    fill_rows(5, 4);
    add(5, 1, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 32'h0, 3);
    add(5, 1, 1, 0, 1, 32'h80, 0, 0, 0, 1, 1, 0, 32'h0, 4);
    add(5, 1, 1, 1, 0, 0, 0, 1, 32, 1, 0, 0, 32'h0, 0);
    add(5, 1, 1, 1, 0, 0, 0, 1, 33, 1, 0, 0, 32'h0);
    add(5, 1, 1, 1, 0, 0, 0, 1, 34, 1, 1, 0, 32'h80);
    add(5, 1, 1, 1, 0, 0, 0, 1, 35, 1, 1, 0, 32'h84);
    // seg 6: one-cycle reset mid-stream with three queued
    reset_rows(6, 0);
    fill_rows(6, 4);
    add(6, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 32'h0, 3);
    add(6, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 32'h0, 0);
    add(6, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 32'h0, 0);
    add(6, 1, 1, 0, 0, 0, 0, 1, 2, 1, 1, 0, 32'h0);
    // seg 7: inited low flushes; then a redirect to a target with high/low bits set
    reset_rows(7, 0);
    fill_rows(7, 3);
    add(7, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 32'h0, 2);
    add(7, 1, 1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 32'h0, 0);
    add(7, 1, 1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 32'h0);
    add(7, 1, 1, 0, 0, 0, 0, 1, 5, 1, 1, 0, 32'hC);
    add(7, 1, 1, 0, 1, 32'h0001_000B, 0, 0, 0, 1, 1, 0, 32'hC);
    add(7, 1, 1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 32'h0);
    add(7, 1, 1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 32'h0);
    add(7, 1, 1, 0, 0, 0, 0, 1, 4, 1, 1, 0, 32'h0001_000B);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit i, input bit rd, input bit br,
                       input logic [31:0] tgt);
    rst             = r;
    bus.inited      = i;
    bus.id_ready    = rd;
    bus.branch_flag = br;
    br_target       = tgt;
  endtask

  initial begin
    int pops;
    logic [31:0] exp_pc;
    drive(0, 1, 0, 0, 32'h0);
    build_table();

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(vecs[k].rst, vecs[k].inited, vecs[k].ready, vecs[k].br, vecs[k].tgt);
      #1;
      check($sformatf("s%0d_stall", vecs[k].seg), k, 32'(bus.stall), 32'(vecs[k].stall));
      check($sformatf("s%0d_imem_en", vecs[k].seg), k, 32'(bus.imem_en), 32'(vecs[k].en));
      if (vecs[k].en)
        check($sformatf("s%0d_imem_addr", vecs[k].seg), k, 32'(bus.imem_addr),
              32'(vecs[k].addr));
      if (vecs[k].cq) begin
        check($sformatf("s%0d_id_valid", vecs[k].seg), k, 32'(bus.id_valid),
              32'(vecs[k].valid));
        if (vecs[k].valid) begin
          check($sformatf("s%0d_id_pc", vecs[k].seg), k, bus.id_pc, vecs[k].pc);
          check($sformatf("s%0d_id_inst", vecs[k].seg), k, bus.id_inst, rom_word(vecs[k].pc));
        end else if (vecs[k].zero) begin
          check($sformatf("s%0d_id_pc_zero", vecs[k].seg), k, bus.id_pc, 32'h0);
          check($sformatf("s%0d_id_inst_zero", vecs[k].seg), k, bus.id_inst, 32'h0);
        end
      end
      if (vecs[k].cnt >= 0)
        check($sformatf("s%0d_count", vecs[k].seg), k, 32'(bus.fill_count),
              32'(vecs[k].cnt));
    end

    // Random decode back-pressure: pops must be the sequential PC stream, no loss or duplicate.
    @(negedge clk); drive(0, 1, 0, 0, 32'h0);
    @(negedge clk);
    @(negedge clk); drive(1, 1, 0, 0, 32'h0);
    for (int i = 0; i < 400; i++) exp_q.push_back(32'(i * 4));
    pops = 0;
    for (int c = 0; c < 300; c++) begin
      bus.id_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.id_valid && bus.id_ready) begin
        exp_pc = exp_q.pop_front();
        check("sb_id_pc", c, bus.id_pc, exp_pc);
        check("sb_id_inst", c, bus.id_inst, rom_word(exp_pc));
        pops++;
      end
      @(negedge clk);
    end
    check("sb_enough_pops", pops, 32'(pops >= 100), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
